// File: rtl/seg_scan_capture.sv
// seg_scan_capture: reads a scanned 4-digit active-low 7-segment bus back
// into hex nibbles. A single-anode pattern must stay unchanged for
// STABLE_CYCLES registered samples before it is captured into its digit slot.
//
// Handshake: update is a one-cycle valid strobe with no ready. digits,
// digit_valid and digit_err already hold the new capture in the cycle that
// update is high. A display monitor cannot stall a display, so the consumer
// must sample on the strobe. frame_done is a one-cycle strobe with the same
// rule.
module seg_scan_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg_n,
  input  logic [3:0]  an_n,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic [3:0]  digit_err,
  output logic        update,
  output logic        frame_done,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    CAPTURE = 2'd2,
    HELD    = 2'd3
  } state_t;

  localparam logic [7:0] STABLE_TARGET = 8'(STABLE_CYCLES);

  state_t      state, state_next;
  logic [7:0]  cnt, cnt_next;
  logic [6:0]  cur_seg, prev_seg;
  logic [3:0]  cur_an, prev_an;
  logic [3:0]  an_sel;
  logic        one_hot;
  logic        changed;
  logic        capture;
  logic [1:0]  sel_idx;
  logic [4:0]  decoded;
  logic [3:0]  seen;

  // Reverse of the hex-to-segment table. bit 4 = legal, bits 3:0 = nibble.
  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h01:   r = 5'h10;
      7'h4F:   r = 5'h11;
      7'h12:   r = 5'h12;
      7'h06:   r = 5'h13;
      7'h4C:   r = 5'h14;
      7'h24:   r = 5'h15;
      7'h20:   r = 5'h16;
      7'h0F:   r = 5'h17;
      7'h00:   r = 5'h18;
      7'h04:   r = 5'h19;
      7'h08:   r = 5'h1A;
      7'h60:   r = 5'h1B;
      7'h31:   r = 5'h1C;
      7'h42:   r = 5'h1D;
      7'h30:   r = 5'h1E;
      7'h38:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // Register the pins once, and keep the previous sample for change detection.
  // The anode reset value is "no anode", so a hold across reset starts a fresh window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_seg  <= 7'h7F;
      cur_an   <= 4'hF;
      prev_seg <= 7'h7F;
      prev_an  <= 4'hF;
    end else begin
      cur_seg  <= seg_n;
      cur_an   <= an_n;
      prev_seg <= cur_seg;
      prev_an  <= cur_an;
    end
  end

  // Decode the sampled anodes into a one-hot flag and a digit index.
  always_comb begin
    an_sel  = ~cur_an;
    one_hot = (an_sel != 4'd0) && ((an_sel & (an_sel - 4'd1)) == 4'd0);
    changed = (cur_seg != prev_seg) || (cur_an != prev_an);
    decoded = decode_seg(cur_seg);
    sel_idx = 2'd0;
    case (an_sel)
      4'b0010: sel_idx = 2'd1;
      4'b0100: sel_idx = 2'd2;
      4'b1000: sel_idx = 2'd3;
      default: sel_idx = 2'd0;
    endcase
  end

  // Next-state logic for the stability FSM.
  // A new window counts as 1. Reaching the target enters CAPTURE at the same
  // edge, so a capture lands exactly STABLE_CYCLES edges after the pins are sampled.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        cnt_next = 8'd0;
        if (one_hot) begin
          state_next = COUNT;
          cnt_next   = 8'd1;
        end
      end
      COUNT: begin
        if (!one_hot) begin
          state_next = IDLE;
          cnt_next   = 8'd0;
        end else if (changed) begin
          cnt_next = 8'd1;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      CAPTURE, HELD: begin
        state_next = HELD;
        if (changed) begin
          if (!one_hot) begin
            state_next = IDLE;
            cnt_next   = 8'd0;
          end else begin
            state_next = COUNT;
            cnt_next   = 8'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 8'd0;
      end
    endcase
    if (state_next == COUNT && cnt_next == STABLE_TARGET) begin
      state_next = CAPTURE;
    end
    capture = (state_next == CAPTURE);
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Capture into the selected slot. An illegal pattern only flags the error.
  // seen clears when frame_done fires, and a capture in that same cycle is kept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits      <= 16'd0;
      digit_valid <= 4'd0;
      digit_err   <= 4'd0;
      seen        <= 4'd0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= (seen == 4'hF);
      seen       <= ((seen == 4'hF) ? 4'd0 : seen) |
                    (capture ? (4'd1 << sel_idx) : 4'd0);
      if (capture) begin
        if (decoded[4]) begin
          digits[{sel_idx, 2'b00} +: 4] <= decoded[3:0];
          digit_valid[sel_idx]          <= 1'b1;
          digit_err[sel_idx]            <= 1'b0;
        end else begin
          digit_err[sel_idx] <= 1'b1;
        end
      end
    end
  end

  assign update    = (state == CAPTURE);
  assign state_dbg = state;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Testbench for seg_scan_capture with STABLE_CYCLES=4. It uses directed
// vectors. Each expected capture snapshot {digits, digit_valid, digit_err} is
// queued when the stimulus is issued. A monitor pops the queue on every
// update pulse.
module tb_seg_scan_capture;

  logic        clk;
  logic        reset;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic [3:0]  digit_err;
  logic        update;
  logic        frame_done;
  logic [1:0]  state_dbg;

  logic [23:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          upd_cnt = 0;
  int          frm_cnt = 0;

  seg_scan_capture #(.STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .digits      (digits),
    .digit_valid (digit_valid),
    .digit_err   (digit_err),
    .update      (update),
    .frame_done  (frame_done),
    .state_dbg   (state_dbg)
  );

  // Clock and run-time guard.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks + 1);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one pattern at a falling edge and hold it for n cycles.
  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
    @(negedge clk);
    an_n  = an;
    seg_n = seg;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_digits"}, 32'(digits), 32'h0);
    check({tag, "_valid"},  32'(digit_valid), 32'h0);
    check({tag, "_err"},    32'(digit_err), 32'h0);
    check({tag, "_update"}, 32'(update), 32'h0);
    check({tag, "_frame"},  32'(frame_done), 32'h0);
    check({tag, "_state"},  32'(state_dbg), 32'h0);
  endtask

  // Monitor: pop the scoreboard on every update pulse, and count frame_done.
  always @(negedge clk) begin
    if (!reset) begin
      if (update) begin
        upd_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_update: got %h expected none",
                   {digits, digit_valid, digit_err});
        end else begin
          check("capture_snapshot", 32'({digits, digit_valid, digit_err}), 32'(exp_q.pop_front()));
        end
      end
      if (frame_done) frm_cnt++;
    end
  end

  logic [3:0]  scan_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0]  scan_seg [4] = '{7'h01, 7'h0F, 7'h20, 7'h38};
  logic [15:0] scan_dig [4] = '{16'h0000, 16'h0070, 16'h0670, 16'hF670};
  logic [3:0]  scan_val [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};

  initial begin
    // Reset values.
    reset = 1'b1;
    seg_n = 7'h7F;
    an_n  = 4'hF;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    settle(2);

    // Single digit 1 on position 0, including an exact latency check.
    @(negedge clk);
    an_n  = 4'b1110;
    seg_n = 7'h4F;
    exp_q.push_back({16'h0001, 4'b0001, 4'b0000});
    repeat (4) @(posedge clk);
    #1;
    check("lat_early_update", 32'(update), 32'h0);
    @(posedge clk);
    #1;
    check("lat_update", 32'(update), 32'h1);
    check("lat_digit0", 32'(digits[3:0]), 32'h1);
    settle(6);
    check("single_upd_cnt", 32'(upd_cnt), 32'd1);
    check("single_frame_cnt", 32'(frm_cnt), 32'd0);
    check("single_valid", 32'(digit_valid), 32'h1);

    // Two full scans. Each completed frame gives exactly one frame_done.
    for (int pass = 0; pass < 2; pass++) begin
      for (int d = 0; d < 4; d++) begin
        exp_q.push_back(pass == 0 ? {scan_dig[d], scan_val[d], 4'b0000}
                                  : {16'hF670, 4'b1111, 4'b0000});
        drive(scan_an[d], scan_seg[d], 6);
      end
      settle(2);
      check("scan_digits", 32'(digits), 32'hF670);
      check("scan_valid", 32'(digit_valid), 32'hF);
      check("scan_upd_cnt", 32'(upd_cnt), 32'(1 + 4 * (pass + 1)));
      check("scan_frame_cnt", 32'(frm_cnt), 32'(pass + 1));
    end

    // A blank pattern on digit 0 flags an error and keeps the old nibble.
    exp_q.push_back({16'hF670, 4'b1111, 4'b0001});
    drive(4'b1110, 7'h7F, 6);
    settle(2);
    check("illegal_err", 32'(digit_err), 32'h1);
    check("illegal_digit0", 32'(digits[3:0]), 32'h0);
    check("illegal_valid", 32'(digit_valid), 32'hF);
    check("illegal_upd_cnt", 32'(upd_cnt), 32'd10);

    // Segments toggling faster than the window never capture.
    for (int k = 0; k < 8; k++) begin
      drive(4'b1101, (k % 2 == 0) ? 7'h00 : 7'h01, 3);
    end
    // Two anodes at once: stay idle.
    drive(4'b1100, 7'h00, 20);
    #1;
    check("unstable_upd_cnt", 32'(upd_cnt), 32'd10);
    check("unstable_digits", 32'(digits), 32'hF670);
    check("two_anode_state", 32'(state_dbg), 32'h0);

    // Reset in mid-count clears everything. A full window is needed after release.
    @(negedge clk);
    an_n  = 4'b1110;
    seg_n = 7'h4F;
    repeat (4) @(posedge clk);
    #1;
    check("midcnt_no_update", 32'(update), 32'h0);
    reset = 1'b1;
    #1;
    check_all_zero("midrst");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.push_back({16'h0001, 4'b0001, 4'b0000});
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_early", 32'(update), 32'h0);
    @(posedge clk);
    #1;
    check("post_rst_update", 32'(update), 32'h1);
    check("post_rst_digits", 32'(digits), 32'h0001);
    settle(4);

    check("final_upd_cnt", 32'(upd_cnt), 32'd11);
    check("final_frame_cnt", 32'(frm_cnt), 32'd2);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
